// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write counters from issue to writeback,
// producing decode stall on RAW and counter-overflow hazards.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned CNT_W          = 3,
    parameter int unsigned NUM_WB         = 2,
    parameter int unsigned BYPASS_WB      = 1,
    parameter int unsigned HARDWIRED_ZERO = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         issue_valid,
    input  logic                         issue_we,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    input  logic [REG_ADDR_W-1:0]        issue_rs1,
    input  logic [REG_ADDR_W-1:0]        issue_rs2,
    input  logic                         issue_rs1_used,
    input  logic                         issue_rs2_used,
    input  logic [NUM_WB-1:0]            wb_en,
    input  logic [NUM_WB*REG_ADDR_W-1:0] wb_rd,
    input  logic                         flush,
    output logic                         stall,
    output logic                         issue_fire,
    output logic [NUM_REGS-1:0]          busy_vec,
    output logic                         inflight_any,
    output logic                         err_underflow
);

    localparam int unsigned DEC_W = $clog2(NUM_WB + 1);
    localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_REGS-1:0][DEC_W-1:0] dec;
    logic [NUM_REGS-1:0]            eff_busy;
    logic [NUM_REGS-1:0]            busy_q, busy_d;
    logic                           inflight_q, inflight_d;
    logic                           err_q, err_d;
    logic                           haz_rs1, haz_rs2, haz_full, underflow;

    // x0 (optionally) and out-of-range indices are never tracked
    function automatic logic tracked(input logic [REG_ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !((HARDWIRED_ZERO != 0) && (a == '0));
    endfunction

    // Retire counts per register and hazard detection
    always_comb begin
        dec      = '0;
        eff_busy = '0;
        haz_rs1  = 1'b0;
        haz_rs2  = 1'b0;
        haz_full = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            for (int p = 0; p < int'(NUM_WB); p++) begin
                if (wb_en[p] && tracked(wb_rd[p*REG_ADDR_W +: REG_ADDR_W]) &&
                    (wb_rd[p*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
                    dec[r] = dec[r] + DEC_W'(1);
                end
            end
            if (BYPASS_WB != 0) begin
                eff_busy[r] = SUM_W'(cnt_q[r]) > SUM_W'(dec[r]);
            end else begin
                eff_busy[r] = cnt_q[r] != '0;
            end
            if (issue_rs1 == REG_ADDR_W'(r)) begin
                haz_rs1 = issue_rs1_used && tracked(issue_rs1) && eff_busy[r];
            end
            if (issue_rs2 == REG_ADDR_W'(r)) begin
                haz_rs2 = issue_rs2_used && tracked(issue_rs2) && eff_busy[r];
            end
            if (issue_rd == REG_ADDR_W'(r)) begin
                haz_full = issue_we && tracked(issue_rd) && (cnt_q[r] == '1);
            end
        end
    end

    assign stall      = issue_valid && (haz_rs1 || haz_rs2 || haz_full);
    assign issue_fire = issue_valid && !stall && !flush;

    // Counter update; underflow saturates at zero, flush wins over everything
    always_comb begin
        logic             inc;
        logic [SUM_W-1:0] sum;
        cnt_d     = cnt_q;
        underflow = 1'b0;
        inc       = 1'b0;
        sum       = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            inc = issue_fire && issue_we && tracked(issue_rd) &&
                  (issue_rd == REG_ADDR_W'(r));
            sum = SUM_W'(cnt_q[r]) + SUM_W'(inc);
            if (SUM_W'(dec[r]) > sum) begin
                cnt_d[r]  = '0;
                underflow = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum - SUM_W'(dec[r]));
            end
        end
        if (flush) begin
            cnt_d = '0;
        end
        err_d = err_q || (underflow && !flush);
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            busy_d[r] = cnt_d[r] != '0;
        end
        inflight_d = |busy_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            busy_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign busy_vec      = busy_q;
    assign inflight_any  = inflight_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: bypass and non-bypass instances share all inputs.
module tb_reg_scoreboard;

    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NW = 2;

    logic           clk = 1'b0;
    logic           rstn;
    logic           issue_valid, issue_we, issue_rs1_used, issue_rs2_used, flush;
    logic [AW-1:0]  issue_rd, issue_rs1, issue_rs2;
    logic [NW-1:0]  wb_en;
    logic [NW*AW-1:0] wb_rd;

    logic           stall_a, fire_a, infl_a, err_a;
    logic [NR-1:0]  busy_a;
    logic           stall_b, fire_b, infl_b, err_b;
    logic [NR-1:0]  busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.BYPASS_WB(1)) u_byp (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush), .stall(stall_a),
        .issue_fire(fire_a), .busy_vec(busy_a), .inflight_any(infl_a),
        .err_underflow(err_a)
    );

    reg_scoreboard #(.BYPASS_WB(0)) u_nobyp (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
        .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush), .stall(stall_b),
        .issue_fire(fire_b), .busy_vec(busy_b), .inflight_any(infl_b),
        .err_underflow(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_we       = 1'b0;
        issue_rd       = '0;
        issue_rs1      = '0;
        issue_rs2      = '0;
        issue_rs1_used = 1'b0;
        issue_rs2_used = 1'b0;
        wb_en          = '0;
        wb_rd          = '0;
        flush          = 1'b0;
    endtask

    // Advance to the next falling edge; inputs change there, checks follow 1 time unit later
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue_wr(input logic [AW-1:0] rd);
        idle();
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_rd    = rd;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        cyc(); #1;
        check("rst_busy", busy_a, 32'h0);
        check("rst_infl", 32'(infl_a), 32'h0);
        check("rst_err", 32'(err_a), 32'h0);
        check("rst_stall", 32'(stall_a), 32'h0);
        rstn = 1'b1;

        // RAW hazard on x5
        cyc(); issue_wr(5'd5); #1;
        check("raw_issue_fire", 32'(fire_a), 32'h1);
        cyc(); idle(); issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs1_used = 1'b1; #1;
        check("raw_stall_a", 32'(stall_a), 32'h1);
        check("raw_stall_b", 32'(stall_b), 32'h1);
        check("raw_busy", busy_a, 32'h0000_0020);
        check("raw_infl", 32'(infl_a), 32'h1);
        cyc(); wb_en = 2'b01; wb_rd = {5'd0, 5'd5}; #1;
        check("byp_stall_wb", 32'(stall_a), 32'h0);
        check("byp_fire_wb", 32'(fire_a), 32'h1);
        check("nobyp_stall_wb", 32'(stall_b), 32'h1);
        check("busy_during_wb", busy_a, 32'h0000_0020);
        cyc(); wb_en = 2'b00; #1;
        check("nobyp_stall_after", 32'(stall_b), 32'h0);
        check("busy_after_wb", busy_a, 32'h0);
        check("busy_b_after_wb", busy_b, 32'h0);

        // Counter overflow on x3
        for (int i = 0; i < 7; i++) begin
            cyc(); issue_wr(5'd3); #1;
            check("ovf_fill_fire", 32'(fire_a), 32'h1);
        end
        cyc(); issue_wr(5'd3); #1;
        check("ovf_stall", 32'(stall_a), 32'h1);
        check("ovf_fire", 32'(fire_a), 32'h0);
        check("ovf_busy", busy_a, 32'h0000_0008);
        cyc(); wb_en = 2'b01; wb_rd = {5'd0, 5'd3}; #1;
        check("ovf_stall_wb", 32'(stall_a), 32'h1);
        cyc(); wb_en = 2'b00; #1;
        check("ovf_release", 32'(stall_a), 32'h0);
        check("ovf_release_fire", 32'(fire_a), 32'h1);

        // x0 untracked, same-cycle issue+retire, dual-port retire (cnt[3]=7 now)
        cyc(); issue_wr(5'd0); #1;
        cyc(); idle(); #1;
        check("x0_busy", busy_a, 32'h0000_0008);
        cyc(); issue_wr(5'd4); #1;
        cyc(); issue_wr(5'd4); wb_en = 2'b01; wb_rd = {5'd0, 5'd4}; #1;
        check("sim_busy_before", busy_a, 32'h0000_0018);
        cyc(); issue_wr(5'd4); #1;
        check("sim_busy_after", busy_a, 32'h0000_0018);
        cyc(); idle(); wb_en = 2'b11; wb_rd = {5'd4, 5'd4}; #1;
        cyc(); idle(); #1;
        check("dual_wb_busy", busy_a, 32'h0000_0008);
        check("dual_wb_err", 32'(err_a), 32'h0);

        // Underflow on x9 via port 1
        cyc(); wb_en = 2'b10; wb_rd = {5'd9, 5'd0}; #1;
        cyc(); idle(); #1;
        check("unf_err", 32'(err_a), 32'h1);
        check("unf_busy", busy_a, 32'h0000_0008);
        cyc(); #1;
        check("unf_sticky", 32'(err_b), 32'h1);

        // Flush with three busy registers and a concurrent issue of x7
        cyc(); issue_wr(5'd1); #1;
        cyc(); issue_wr(5'd2); #1;
        cyc(); issue_wr(5'd7); flush = 1'b1; #1;
        check("fl_busy_before", busy_a, 32'h0000_000e);
        check("fl_fire", 32'(fire_a), 32'h0);
        check("fl_stall", 32'(stall_a), 32'h0);
        cyc(); idle(); issue_valid = 1'b1; issue_rs1 = 5'd7; issue_rs1_used = 1'b1; #1;
        check("fl_busy_after", busy_a, 32'h0);
        check("fl_infl_after", 32'(infl_a), 32'h0);
        check("fl_rs7_stall", 32'(stall_a), 32'h0);
        check("fl_err_kept", 32'(err_a), 32'h1);

        // Asynchronous reset between clock edges
        cyc(); issue_wr(5'd6); #1;
        cyc(); idle(); #1;
        check("ar_busy_pre", busy_a, 32'h0000_0040);
        #1 rstn = 1'b0;
        #1;
        check("ar_busy", busy_a, 32'h0);
        check("ar_infl", 32'(infl_a), 32'h0);
        check("ar_err", 32'(err_a), 32'h0);
        check("ar_err_b", 32'(err_b), 32'h0);
        cyc(); rstn = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register-hazard scoreboard for the pipelined core. It tracks how many in-flight instructions target each destination register, from the issue point at decode to the retirement point at writeback. It stalls decode on read-after-write and write-count-overflow hazards. It supports multiple writeback ports (integer and FP pipes) and an optional same-cycle writeback bypass.

## Interface
Parameters:
- NUM_REGS, 32: number of architectural registers tracked.
- REG_ADDR_W, 5: register index width; NUM_REGS ≤ 2^REG_ADDR_W.
- CNT_W, 3: per-register in-flight counter width; at most 2^CNT_W−1 outstanding writes per register.
- NUM_WB, 2: number of writeback ports.
- BYPASS_WB, 1: 1 means a retiring write in the current cycle resolves the hazard in the same cycle.
- HARDWIRED_ZERO, 1: 1 means register 0 is never tracked (x0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode presents an instruction.
- issue_we  in  1  the instruction writes a destination register.
- issue_rd  in  REG_ADDR_W  destination index.
- issue_rs1, issue_rs2  in  REG_ADDR_W each  source indices.
- issue_rs1_used, issue_rs2_used  in  1 each  the source is actually read.
- wb_en  in  NUM_WB  per-port retire strobe.
- wb_rd  in  NUM_WB×REG_ADDR_W  per-port retiring index, packed, port 0 in the LSBs.
- flush  in  1  pipeline flush; discards all in-flight writes.
- stall  out  1  decode must hold; the instruction is not accepted.
- issue_fire  out  1  issue_valid & ~stall & ~flush.
- busy_vec  out  NUM_REGS  bit r = registered cnt[r] ≠ 0.
- inflight_any  out  1  OR of busy_vec.
- err_underflow  out  1  sticky; set when a retire hits a zero counter.

## Operation
- State: cnt[r] for each register, CNT_W bits; err_underflow flop.
- Source hazard:
  - haz_rsN = issue_rsN_used & tracked(rsN) & (eff_cnt[rsN] ≠ 0).
  - eff_cnt = cnt − (number of wb ports retiring that reg this cycle) when BYPASS_WB=1, else cnt.
- Overflow hazard: haz_full = issue_we & tracked(rd) & (cnt[rd] = 2^CNT_W−1).
- stall = issue_valid & (haz_rs1 | haz_rs2 | haz_full). Combinational; not gated by flush.
- tracked(r) = 0 when HARDWIRED_ZERO=1 and r=0; indices ≥ NUM_REGS are ignored and never busy.
- Counter update per register r, next edge:
  - inc = issue_fire & issue_we & tracked(issue_rd) & (issue_rd = r).
  - dec = count of ports p with wb_en[p] & tracked(wb_rd[p]) & (wb_rd[p] = r). Ports addressing the same r sum.
  - The nominal next value is cnt + inc − dec. Issue and retire on the same register in the same cycle gives a net change of 0.
  - If dec > cnt + inc, the counter saturates at 0 and err_underflow is set.
- flush has priority: all cnt clear to 0 next edge. Issue and wb in the flush cycle are discarded, and no underflow is flagged from them.
- err_underflow clears only on reset.

## Timing
- Reset: all cnt = 0, err_underflow = 0. Outputs while rstn = 0: busy_vec = 0, inflight_any = 0, err_underflow = 0. stall and issue_fire follow inputs, and with all counters 0 they can only assert via haz_full, which is impossible at reset.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.
- Issue-to-visibility latency is 1 cycle: busy_vec and hazards reflect an accepted issue from the next cycle.
- Retire-to-release latency:
  - 0 cycles when BYPASS_WB=1; stall drops in the same cycle as wb_en.
  - 1 cycle when BYPASS_WB=0.
- While stall is high, decode keeps all issue_* stable; the scoreboard holds no state for a stalled instruction.
- Flush-to-clear latency is 1 cycle; stall is 0 from the cycle after flush unless new hazards arise.

## Test plan
- RAW with bypass (BYPASS_WB=1): issue rd=5; next cycle issue rs1=5. Expect stall=1 and busy_vec[5]=1. Assert wb_en[0] with wb_rd=5: stall=0 in that same cycle, and busy_vec[5]=0 on the next edge.
- RAW without bypass (BYPASS_WB=0): same sequence. Expect stall to stay 1 during the wb cycle and drop one cycle later.
- Overflow (CNT_W=3): issue 7 writes to rd=3 with no retires. The 8th issue with rd=3 gives stall=1 and issue_fire=0. One retire of 3 releases it.
- x0 and simultaneity: issue rd=0 → busy_vec stays 0. With cnt[4]=1, issue rd=4 while wb rd=4 in the same cycle → cnt[4] remains 1. Both wb ports retiring rd=4 when cnt[4]=2 → 0.
- Underflow: wb_en[1] with wb_rd=9 while cnt[9]=0 → err_underflow=1 and stays set; cnt[9] stays 0. Only rstn clears the flag.
- Flush and reset: with 3 registers busy, assert flush together with an issue of rd=7 → next cycle busy_vec=0 and cnt[7]=0. Asserting rstn low mid-run clears all outputs asynchronously.
